// File: rtl/fir_coef_loader.sv
// Builds a symmetric FIR coefficient table by driving the window-coefficient
// generator once per unique tap and mirroring each result into the coefficient RAM.
module fir_coef_loader #(
  parameter int MAX_TAPS = 256,
  parameter int AW       = 8,
  parameter int COEF_W   = 16,
  parameter int TIMEOUT  = 64,
  parameter int EN_HOLD  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       n,
  output logic              gen_en,
  output logic [15:0]       gen_i,
  output logic [15:0]       gen_n,
  input  logic              gen_busy,
  input  logic [COEF_W-1:0] gen_firwin,
  input  logic [AW-1:0]     rd_addr,
  output logic [COEF_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              coef_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_PULSE, S_WAIT_HI, S_WAIT_LO, S_CAPTURE,
    S_WR_A, S_WR_B, S_NEXT, S_DONE, S_ERR
  } state_t;

  localparam logic [15:0] N_MAX    = 16'(MAX_TAPS - 1);
  localparam logic [15:0] HOLD_END = 16'(EN_HOLD - 1);
  localparam logic [15:0] TMO_END  = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [15:0]         i_q, i_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [COEF_W-1:0]   coef_q, coef_d;
  logic                gen_en_q, gen_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic [COEF_W-1:0]   rd_data_q;
  logic [15:0]         n_minus_i;
  logic                we;
  logic [AW-1:0]       wr_addr;

  logic [COEF_W-1:0]   mem [MAX_TAPS];

  assign n_minus_i = n_q - i_q;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    coef_d  = coef_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = n;
          i_d     = '0;
          valid_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d   = '0;
        state_d = (n_q > N_MAX) ? S_ERR : S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == HOLD_END) begin
          cnt_d   = '0;
          state_d = S_WAIT_HI;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_HI: begin
        if (gen_busy) begin
          cnt_d   = '0;
          state_d = S_WAIT_LO;
        end else if (cnt_q == TMO_END) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_LO: begin
        if (!gen_busy) begin
          state_d = S_CAPTURE;
        end else if (cnt_q == TMO_END) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CAPTURE: begin
        coef_d  = gen_firwin;
        state_d = S_WR_A;
      end
      // The centre tap of an even order maps onto itself, so it gets one write.
      S_WR_A:  state_d = (n_minus_i != i_q) ? S_WR_B : S_NEXT;
      S_WR_B:  state_d = S_NEXT;
      S_NEXT: begin
        if (i_q == {1'b0, n_q[15:1]}) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 16'd1;
          cnt_d   = '0;
          state_d = S_PULSE;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    gen_en_d = (state_d == S_PULSE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      i_q      <= '0;
      cnt_q    <= '0;
      coef_q   <= '0;
      gen_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      i_q      <= i_d;
      cnt_q    <= cnt_d;
      coef_q   <= coef_d;
      gen_en_q <= gen_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    we      = (state_q == S_WR_A) || (state_q == S_WR_B);
    wr_addr = (state_q == S_WR_B) ? n_minus_i[AW-1:0] : i_q[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= coef_q;
    end
  end

  // Read-before-write: a same-address collision returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign gen_en     = gen_en_q;
  assign gen_i      = i_q;
  assign gen_n      = n_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign coef_valid = valid_q;

endmodule
